// File: rtl/stall_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline control path:
//   - ctrl_state_t        : stall controller state encoding (RUN / MD_BUSY)
//   - DEFAULT_MUL_CYCLES  : EX-stage occupancy of a multiply (also used by the
//                           mul/div datapath)
//   - DEFAULT_DIV_CYCLES  : EX-stage occupancy of a divide/remainder
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_t;

    localparam int DEFAULT_MUL_CYCLES = 2;
    localparam int DEFAULT_DIV_CYCLES = 32;

    localparam logic [31:0] STALL_COUNT_MAX = 32'hFFFF_FFFF;

endpackage : pipeline_ctrl_pkg

// File: rtl/stall_control_unit_if.sv
// -----------------------------------------------------------------------------
// stall_control_unit_if
// Groups the hazard/redirect/mul-div inputs and all pipeline control outputs
// of the stall controller.
//   master : pipeline side (drives hazard/branch/muldiv, consumes controls)
//   slave  : stall controller
// Signals:
//   LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_EN_EX, DIV_EX        -> controller
//   PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_WRITE_EN,
//   ID_EX_BUBBLE, EX_MEM_BUBBLE, MULDIV_DONE, STALL_COUNT   <- controller
//   DBG_STATE                                               <- controller FSM state
// These are level signals sampled every clock; there is no valid/ready
// handshake: each output is valid for the cycle in which it is presented.
// -----------------------------------------------------------------------------
interface stall_control_unit_if;
    import pipeline_ctrl_pkg::*;

    logic        LU_HAZARD;
    logic        BRANCH_TAKEN_EX;
    logic        MULDIV_EN_EX;
    logic        DIV_EX;
    logic        PC_WRITE_EN;
    logic        IF_ID_WRITE_EN;
    logic        IF_ID_FLUSH;
    logic        ID_EX_WRITE_EN;
    logic        ID_EX_BUBBLE;
    logic        EX_MEM_BUBBLE;
    logic        MULDIV_DONE;
    logic [31:0] STALL_COUNT;
    ctrl_state_t DBG_STATE;

    modport master (
        output LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_EN_EX, DIV_EX,
        input  PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_WRITE_EN,
        input  ID_EX_BUBBLE, EX_MEM_BUBBLE, MULDIV_DONE, STALL_COUNT, DBG_STATE
    );

    modport slave (
        input  LU_HAZARD, BRANCH_TAKEN_EX, MULDIV_EN_EX, DIV_EX,
        output PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EX_WRITE_EN,
        output ID_EX_BUBBLE, EX_MEM_BUBBLE, MULDIV_DONE, STALL_COUNT, DBG_STATE
    );

endinterface : stall_control_unit_if

// File: rtl/stall_control_unit_latency_counter.sv
// -----------------------------------------------------------------------------
// muldiv_latency_counter
// Loadable down-counter tracking the remaining busy cycles of a mul/div.
// Ports:
//   clk        in  : clock
//   rst_n      in  : asynchronous active-low reset (clears count)
//   i_load     in  : load i_load_val (has priority over decrement)
//   i_load_val in  : value to load
//   i_dec      in  : decrement by one (ignored at zero)
//   o_zero     out : count is zero
// -----------------------------------------------------------------------------
module muldiv_latency_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : muldiv_latency_counter

// File: rtl/stall_control_unit.sv
// -----------------------------------------------------------------------------
// stall_control_unit
// Central stall/flush controller for the 5-stage RV32IM pipeline. Resolves
// taken-branch redirects, multi-cycle mul/div occupancy of EX and load-use
// hazards into pipeline-register enables, flushes and bubbles, and keeps a
// saturating count of cycles in which the PC was held.
// Ports:
//   CLK    in : clock, rising edge
//   RESET  in : asynchronous active-low reset
//   bus       : stall_control_unit_if.slave (hazard inputs, control outputs,
//               STALL_COUNT, DBG_STATE)
// Parameters:
//   MUL_CYCLES : EX occupancy of a multiply (>= 2)
//   DIV_CYCLES : EX occupancy of a divide/remainder (>= MUL_CYCLES)
// -----------------------------------------------------------------------------
module stall_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RESET,
    stall_control_unit_if.slave  bus
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    // The start cycle is itself a stall and the final cycle is the done
    // cycle, so the counter only has to cover the N-2 cycles in between.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    ctrl_state_t r_state;
    logic [31:0] r_stall_count;

    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_we;
    logic w_idex_bubble;
    logic w_exmem_bubble;
    logic w_md_done;
    logic w_md_start;
    logic w_md_dec;
    logic w_md_zero;
    logic [CNT_W-1:0] w_md_load_val;

    assign w_md_load_val = bus.DIV_EX ? DIV_LOAD : MUL_LOAD;

    muldiv_latency_counter #(
        .W (CNT_W)
    ) u_md_cnt (
        .clk        (CLK),
        .rst_n      (RESET),
        .i_load     (w_md_start),
        .i_load_val (w_md_load_val),
        .i_dec      (w_md_dec),
        .o_zero     (w_md_zero)
    );

    // Output decode. Everything is forced low while RESET is asserted so the
    // pipeline registers stay frozen during reset.
    always_comb begin
        w_pc_we        = 1'b0;
        w_ifid_we      = 1'b0;
        w_ifid_flush   = 1'b0;
        w_idex_we      = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;
        w_md_done      = 1'b0;
        w_md_start     = 1'b0;
        w_md_dec       = 1'b0;
        if (RESET) begin
            case (r_state)
                RUN: begin
                    if (bus.BRANCH_TAKEN_EX) begin
                        // ID instruction is squashed, so its hazards are moot.
                        w_pc_we       = 1'b1;
                        w_ifid_we     = 1'b1;
                        w_idex_we     = 1'b1;
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (bus.MULDIV_EN_EX) begin
                        w_exmem_bubble = 1'b1;
                        w_md_start     = 1'b1;
                    end else if (bus.LU_HAZARD) begin
                        w_idex_we     = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else begin
                        w_pc_we   = 1'b1;
                        w_ifid_we = 1'b1;
                        w_idex_we = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (!w_md_zero) begin
                        w_exmem_bubble = 1'b1;
                        w_md_dec       = 1'b1;
                    end else begin
                        w_md_done = 1'b1;
                        w_pc_we   = 1'b1;
                        w_ifid_we = 1'b1;
                        w_idex_we = 1'b1;
                    end
                end
                default: begin
                    w_pc_we   = 1'b1;
                    w_ifid_we = 1'b1;
                    w_idex_we = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (w_md_start) r_state <= MD_BUSY;
                MD_BUSY: if (w_md_zero)  r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_count <= '0;
        end else if (!w_pc_we && (r_stall_count != STALL_COUNT_MAX)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.PC_WRITE_EN    = w_pc_we;
    assign bus.IF_ID_WRITE_EN = w_ifid_we;
    assign bus.IF_ID_FLUSH    = w_ifid_flush;
    assign bus.ID_EX_WRITE_EN = w_idex_we;
    assign bus.ID_EX_BUBBLE   = w_idex_bubble;
    assign bus.EX_MEM_BUBBLE  = w_exmem_bubble;
    assign bus.MULDIV_DONE    = w_md_done;
    assign bus.STALL_COUNT    = r_stall_count;
    assign bus.DBG_STATE      = r_state;

endmodule : stall_control_unit

// File: tb/tb_stall_control_unit.sv
// -----------------------------------------------------------------------------
// tb_stall_control_unit
// Self-checking bench for stall_control_unit with default cycle parameters.
// The reference model tracks how many EX cycles of the current mul/div remain
// and the expected stall total, and derives expected controls from the
// branch > mul/div > load-use > normal rules.
// -----------------------------------------------------------------------------
module tb_stall_control_unit;
    import pipeline_ctrl_pkg::*;

    localparam int MUL_N = DEFAULT_MUL_CYCLES;
    localparam int DIV_N = DEFAULT_DIV_CYCLES;

    // Output vector order:
    // {PC_WE, IFID_WE, IFID_FLUSH, IDEX_WE, IDEX_BUBBLE, EXMEM_BUBBLE, DONE}
    localparam logic [6:0] V_ZERO   = 7'b000_0000;
    localparam logic [6:0] V_NORMAL = 7'b110_1000;
    localparam logic [6:0] V_BRANCH = 7'b111_1100;
    localparam logic [6:0] V_MDSTL  = 7'b000_0010;
    localparam logic [6:0] V_LU     = 7'b000_1100;
    localparam logic [6:0] V_DONE   = 7'b110_1001;

    logic clk;
    logic rst_n;

    stall_control_unit_if bus();

    stall_control_unit dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    int n_checks;
    int n_errors;

    // Reference model state
    int          m_md_rem;    // remaining EX cycles of the active mul/div
    logic [31:0] m_count;

    logic [6:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] dut_vec();
        return {bus.PC_WRITE_EN, bus.IF_ID_WRITE_EN, bus.IF_ID_FLUSH,
                bus.ID_EX_WRITE_EN, bus.ID_EX_BUBBLE, bus.EX_MEM_BUBBLE,
                bus.MULDIV_DONE};
    endfunction

    function automatic logic [6:0] model_vec();
        if (!rst_n)                return V_ZERO;
        if (m_md_rem > 1)          return V_MDSTL;
        if (m_md_rem == 1)         return V_DONE;
        if (bus.BRANCH_TAKEN_EX)   return V_BRANCH;
        if (bus.MULDIV_EN_EX)      return V_MDSTL;
        if (bus.LU_HAZARD)         return V_LU;
        return V_NORMAL;
    endfunction

    function automatic ctrl_state_t model_state();
        return (m_md_rem > 0) ? MD_BUSY : RUN;
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_advance();
        logic [6:0] v;
        v = model_vec();
        if (!rst_n) begin
            m_md_rem = 0;
            m_count  = '0;
        end else begin
            if (!v[6] && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (m_md_rem > 0)
                m_md_rem = m_md_rem - 1;
            else if (bus.MULDIV_EN_EX && !bus.BRANCH_TAKEN_EX)
                m_md_rem = (bus.DIV_EX ? DIV_N : MUL_N) - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_inputs(input logic lu, input logic br, input logic md, input logic dv);
        bus.LU_HAZARD       = lu;
        bus.BRANCH_TAKEN_EX = br;
        bus.MULDIV_EN_EX    = md;
        bus.DIV_EX          = dv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_md_rem = 0;
        m_count  = '0;
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== V_ZERO) begin
                n_errors++;
                $display("FAIL reset_outputs: got %b expected %b", dut_vec(), V_ZERO);
            end
            n_checks++;
            if (bus.STALL_COUNT !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_count: got %0d expected 0", bus.STALL_COUNT);
            end
            tick();
        end
        set_inputs(0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== V_NORMAL) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected %b", dut_vec(), V_NORMAL);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] base;
        base = m_count;
        set_inputs(1, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== V_LU) begin
            n_errors++;
            $display("FAIL load_use_stall: got %b expected %b", dut_vec(), V_LU);
        end
        tick();
        set_inputs(0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== V_NORMAL || bus.STALL_COUNT !== base + 32'd1) begin
            n_errors++;
            $display("FAIL load_use_after: got %b cnt %0d expected %b cnt %0d",
                     dut_vec(), bus.STALL_COUNT, V_NORMAL, base + 32'd1);
        end
        tick();
        // Back-to-back hazards: two consecutive stall cycles.
        for (int i = 0; i < 2; i++) begin
            set_inputs(1, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== V_LU) begin
                n_errors++;
                $display("FAIL load_use_b2b: got %b expected %b", dut_vec(), V_LU);
            end
            tick();
        end
        set_inputs(0, 0, 0, 0);
    endtask

    // Runs one mul or div to completion and checks the stall total.
    task automatic test_muldiv(input logic is_div, input int exp_stalls);
        int   stalls;
        logic seen_done;
        logic [31:0] base;
        stalls    = 0;
        seen_done = 1'b0;
        base      = m_count;
        set_inputs(0, 0, 1, is_div);
        for (int i = 0; i < DIV_N + 8 && !seen_done; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== model_vec() || bus.DBG_STATE !== model_state()) begin
                n_errors++;
                $display("FAIL muldiv_cycle: cycle %0d got %b/%0d expected %b/%0d",
                         i, dut_vec(), bus.DBG_STATE, model_vec(), model_state());
            end
            if (!bus.PC_WRITE_EN) stalls++;
            if (bus.MULDIV_DONE) seen_done = 1'b1;
            tick();
        end
        set_inputs(0, 0, 0, 0);
        n_checks++;
        if (!seen_done || stalls != exp_stalls) begin
            n_errors++;
            $display("FAIL muldiv_length: div=%0b done=%0b stalls %0d expected %0d",
                     is_div, seen_done, stalls, exp_stalls);
        end
        @(negedge clk);
        n_checks++;
        if (bus.STALL_COUNT !== base + 32'(exp_stalls)) begin
            n_errors++;
            $display("FAIL muldiv_count: got %0d expected %0d",
                     bus.STALL_COUNT, base + 32'(exp_stalls));
        end
        tick();
    endtask

    task automatic test_branch_priority();
        set_inputs(1, 1, 1, 1);
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== V_BRANCH) begin
            n_errors++;
            $display("FAIL branch_priority: got %b expected %b", dut_vec(), V_BRANCH);
        end
        tick();
        set_inputs(0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== V_NORMAL || bus.DBG_STATE !== RUN) begin
            n_errors++;
            $display("FAIL branch_stays_run: got %b/%0d expected %b/%0d",
                     dut_vec(), bus.DBG_STATE, V_NORMAL, RUN);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        set_inputs(0, 0, 1, 1);
        for (int i = 1; i < 10; i++) tick();
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== V_MDSTL) begin
            n_errors++;
            $display("FAIL abort_pre: got %b expected %b", dut_vec(), V_MDSTL);
        end
        #2;
        rst_n = 1'b0;
        m_md_rem = 0;
        m_count  = '0;
        #1;
        n_checks++;
        if (dut_vec() !== V_ZERO || bus.STALL_COUNT !== 32'd0 || bus.DBG_STATE !== RUN) begin
            n_errors++;
            $display("FAIL abort_async: got %b cnt %0d st %0d expected all zero",
                     dut_vec(), bus.STALL_COUNT, bus.DBG_STATE);
        end
        tick();
        set_inputs(0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < DIV_N + 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== V_NORMAL || bus.STALL_COUNT !== 32'd0) begin
                n_errors++;
                $display("FAIL abort_after: cycle %0d got %b cnt %0d expected %b cnt 0",
                         i, dut_vec(), bus.STALL_COUNT, V_NORMAL);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < MUL_N - 1; s++) exp_q.push_back(V_MDSTL);
            exp_q.push_back(V_DONE);
        end
        set_inputs(0, 0, 1, 0);
        while (exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== e || e !== model_vec()) begin
                n_errors++;
                $display("FAIL back_to_back: got %b expected %b", dut_vec(), e);
            end
            tick();
        end
        set_inputs(0, 0, 0, 0);
        @(negedge clk);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_inputs(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                       1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== model_vec() || bus.STALL_COUNT !== m_count ||
                bus.DBG_STATE !== model_state()) begin
                n_errors++;
                $display("FAIL random: cycle %0d got %b cnt %0d st %0d expected %b cnt %0d st %0d",
                         i, dut_vec(), bus.STALL_COUNT, bus.DBG_STATE,
                         model_vec(), m_count, model_state());
            end
            tick();
        end
        set_inputs(0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        set_inputs(0, 0, 0, 0);
        #1;
        test_reset();
        test_load_use();
        test_muldiv(1'b0, MUL_N - 1);
        test_muldiv(1'b1, DIV_N - 1);
        test_branch_priority();
        test_reset_mid_div();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_stall_control_unit

// File: doc/stall_control_unit.md
# stall_control_unit

Central pipeline stall/flush controller for the 5-stage RV32IM pipeline. It consumes `LU_HAZARD` from the hazard detection unit, the taken-branch redirect from EX, and the multiply/divide start indication from EX. It drives every pipeline-register write enable, flush and bubble control. It owns the multi-cycle mul/div occupancy FSM and a saturating stall-cycle performance counter.

## Interface
- `MUL_CYCLES`, default 2: total EX-stage occupancy of a multiply, in cycles; must be ≥ 2.
- `DIV_CYCLES`, default 32: total EX-stage occupancy of a divide/remainder, in cycles; must be ≥ `MUL_CYCLES`.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `LU_HAZARD` in 1: load-use hazard between EX (load) and ID.
- `BRANCH_TAKEN_EX` in 1: branch/jump resolved taken in EX; PC redirect this cycle.
- `MULDIV_EN_EX` in 1: instruction currently in EX is an M-extension op.
- `DIV_EX` in 1: qualifies `MULDIV_EN_EX`; 1 = div/rem, 0 = mul.
- `PC_WRITE_EN` out 1: PC register update enable.
- `IF_ID_WRITE_EN` out 1: IF/ID register load enable.
- `IF_ID_FLUSH` out 1: IF/ID loads a NOP.
- `ID_EX_WRITE_EN` out 1: ID/EX register load enable.
- `ID_EX_BUBBLE` out 1: ID/EX loads a NOP (control bits cleared).
- `EX_MEM_BUBBLE` out 1: EX/MEM loads a NOP.
- `MULDIV_DONE` out 1: one-cycle pulse in the final EX cycle of a mul/div.
- `STALL_COUNT` out 32: saturating count of stall cycles since reset.

## Operation
- States: `RUN`, `MD_BUSY`. Down-counter `md_cnt`, width `$clog2(DIV_CYCLES)`.
- Priority in `RUN`: branch > mul/div start > load-use > normal.
- `RUN`, `BRANCH_TAKEN_EX`:
  - `IF_ID_FLUSH`=1, `ID_EX_BUBBLE`=1, all write enables 1.
  - Any simultaneous `LU_HAZARD` or `MULDIV_EN_EX` is ignored, because the ID instruction is squashed.
- `RUN`, `MULDIV_EN_EX` (no branch):
  - Stall cycle: `PC_WRITE_EN`=`IF_ID_WRITE_EN`=`ID_EX_WRITE_EN`=0, `EX_MEM_BUBBLE`=1.
  - Load `md_cnt` ← (`DIV_EX` ? `DIV_CYCLES` : `MUL_CYCLES`) − 2.
  - Go to `MD_BUSY`.
- `RUN`, `LU_HAZARD` only: `PC_WRITE_EN`=`IF_ID_WRITE_EN`=0, `ID_EX_BUBBLE`=1, `ID_EX_WRITE_EN`=1.
- `RUN`, no condition: all write enables 1, all flush/bubble outputs 0.
- `MD_BUSY`, `md_cnt` ≠ 0: same outputs as the mul/div stall cycle; decrement `md_cnt`. `LU_HAZARD` and `BRANCH_TAKEN_EX` are ignored.
- `MD_BUSY`, `md_cnt` = 0: `MULDIV_DONE`=1, normal outputs (all enables 1), go to `RUN`.
- `STALL_COUNT` increments on every edge where `PC_WRITE_EN`=0 and `RESET`=1; it holds at 0xFFFF_FFFF.

## Timing
- Outputs are combinational from state and inputs; the FSM, `md_cnt` and `STALL_COUNT` are registered.
- While `RESET`=0:
  - State is `RUN`, `md_cnt`=0, `STALL_COUNT`=0.
  - All write enables, flush, bubble and `MULDIV_DONE` outputs are 0.
- Mul/div EX occupancy is exactly N cycles (N = `MUL_CYCLES` or `DIV_CYCLES`):
  - N−1 stall cycles, then one `MULDIV_DONE` cycle.
  - `MUL_CYCLES`=2 gives 1 stall cycle, then done.
- Load-use stall lasts exactly 1 cycle per `LU_HAZARD` assertion. Back-to-back hazards produce back-to-back stalls.
- A new `MULDIV_EN_EX` in the cycle immediately after `MULDIV_DONE` starts a new sequence with no gap.
- `RESET` asserted mid-`MD_BUSY` aborts the sequence immediately (async). On release the block is in `RUN` and no `MULDIV_DONE` is produced.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - the state encoding constants `RUN`/`MD_BUSY`;
  - the default `MUL_CYCLES`/`DIV_CYCLES` values, which are also used by the mul/div datapath.
- One sub-module, `muldiv_latency_counter`:
  - loadable down-counter with load, value and a zero flag;
  - instantiated once.
- The FSM, output decode and `STALL_COUNT` stay in the top module.

## Test plan
- Reset held 3 cycles with random inputs → all outputs 0, `STALL_COUNT`=0. After release with idle inputs → `PC_WRITE_EN`=`IF_ID_WRITE_EN`=`ID_EX_WRITE_EN`=1.
- `LU_HAZARD` pulse 1 cycle → one cycle of `PC_WRITE_EN`=0, `ID_EX_BUBBLE`=1, then normal; `STALL_COUNT`=1.
- `MULDIV_EN_EX`=1, `DIV_EX`=0, defaults → 1 stall cycle with `EX_MEM_BUBBLE`=1, then a `MULDIV_DONE` pulse. `DIV_EX`=1 → 31 stall cycles then done; `STALL_COUNT`=31.
- `BRANCH_TAKEN_EX`, `LU_HAZARD` and `MULDIV_EN_EX` asserted together → `IF_ID_FLUSH`=`ID_EX_BUBBLE`=1, `PC_WRITE_EN`=1, state stays `RUN`.
- `RESET` dropped at the 10th stall cycle of a divide → outputs 0 immediately. After release: no `MULDIV_DONE`, normal flow, `STALL_COUNT`=0.
- Two back-to-back multiplies (`MULDIV_EN_EX` held high across `MULDIV_DONE`) → pattern stall, done, stall, done with no idle cycle.
